// File: rtl/avmm_burst_reader.sv
// avmm_burst_reader: Avalon-MM burst read master.
// Splits a (byte address, beat length) command into bursts of at most
// MAX_BURST beats. Returned beats are buffered in a beat FIFO and then
// streamed out through a one-beat output register. A burst is issued only
// when every beat already in flight, plus the new burst, still fits in the
// buffer. This means readdata never needs back-pressure.
module avmm_burst_reader #(
    parameter int DATA_W     = 128,
    parameter int ADDR_W     = 32,
    parameter int MAX_BURST  = 8,
    parameter int FIFO_DEPTH = 32,
    parameter int LEN_W      = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [ADDR_W-1:0]              cmd_addr,
    input  logic [LEN_W-1:0]               cmd_len,
    output logic [ADDR_W-1:0]              avm_address,
    output logic [$clog2(MAX_BURST):0]     avm_burstcount,
    output logic                           avm_read,
    input  logic                           avm_waitrequest,
    input  logic [DATA_W-1:0]              avm_readdata,
    input  logic                           avm_readdatavalid,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_W-1:0]              out_data,
    output logic                           out_last,
    output logic                           busy,
    output logic                           done
);

    localparam int BC_W   = $clog2(MAX_BURST) + 1;
    localparam int BSHIFT = $clog2(DATA_W / 8);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int CW     = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;

    logic [ADDR_W-1:0]   addr_r;
    logic [LEN_W-1:0]    issue_rem_r;
    logic [LEN_W-1:0]    len_r;
    logic [LEN_W-1:0]    out_cnt_r;       // beats loaded into the output register
    logic [CW-1:0]       outstanding_r;   // requested beats not yet returned
    logic [CW-1:0]       mem_cnt_r;       // beats held in the FIFO storage
    logic [AW-1:0]       wr_ptr_r;
    logic [AW-1:0]       rd_ptr_r;
    logic [DATA_W-1:0]   mem_r [FIFO_DEPTH];
    logic                out_valid_r;
    logic [DATA_W-1:0]   out_data_r;
    logic                out_last_r;
    logic                done_r;

    logic [BC_W-1:0]     burst_s;
    logic [CW:0]         need_s;
    logic                credit_ok_s;
    logic                avm_read_s;
    logic                issue_accept_s;
    logic                cmd_fire_s;
    logic                rx_s;
    logic                pop_s;
    logic                load_s;
    logic                from_mem_s;
    logic                bypass_s;
    logic                mem_push_s;
    logic                last_pop_s;
    logic [ADDR_W-1:0]   addr_step_s;

    // Burst sizing, credit check and FIFO/output-register steering
    always_comb begin
        if (issue_rem_r >= LEN_W'(MAX_BURST)) begin
            burst_s = BC_W'(MAX_BURST);
        end else begin
            burst_s = issue_rem_r[BC_W-1:0];
        end
        // Buffered beats (FIFO and output register), in-flight beats and the
        // new burst must all fit in FIFO_DEPTH.
        need_s         = (CW+1)'(mem_cnt_r) + (CW+1)'(out_valid_r)
                       + (CW+1)'(outstanding_r) + (CW+1)'(burst_s);
        credit_ok_s    = (need_s <= (CW+1)'(FIFO_DEPTH));
        avm_read_s     = (state_r == ST_ISSUE) && credit_ok_s
                       && (issue_rem_r != {LEN_W{1'b0}});
        issue_accept_s = avm_read_s && !avm_waitrequest;
        addr_step_s    = ADDR_W'(burst_s) << BSHIFT;
        cmd_fire_s     = (state_r == ST_IDLE) && cmd_valid;
        // Beats are dropped when nothing is outstanding, for example after a reset
        rx_s           = avm_readdatavalid && (outstanding_r != {CW{1'b0}});
        pop_s          = out_valid_r && out_ready;
        load_s         = !out_valid_r || out_ready;
        from_mem_s     = load_s && (mem_cnt_r != {CW{1'b0}});
        bypass_s       = load_s && (mem_cnt_r == {CW{1'b0}}) && rx_s;
        mem_push_s     = rx_s && !bypass_s;
        last_pop_s     = pop_s && out_last_r;
    end

    // Next-state logic for the command FSM
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_fire_s && (cmd_len != {LEN_W{1'b0}})) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (last_pop_s) begin
                    state_s = ST_IDLE;
                end else if (issue_accept_s && (issue_rem_r == LEN_W'(burst_s))) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (last_pop_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Command tracking: issue address, remaining beats and in-flight count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_r        <= {ADDR_W{1'b0}};
            issue_rem_r   <= {LEN_W{1'b0}};
            len_r         <= {LEN_W{1'b0}};
            outstanding_r <= {CW{1'b0}};
            done_r        <= 1'b0;
        end else begin
            if (cmd_fire_s) begin
                addr_r      <= cmd_addr;
                issue_rem_r <= cmd_len;
                len_r       <= cmd_len;
            end else if (issue_accept_s) begin
                addr_r      <= addr_r + addr_step_s;
                issue_rem_r <= issue_rem_r - LEN_W'(burst_s);
            end
            outstanding_r <= outstanding_r
                           + (issue_accept_s ? CW'(burst_s) : {CW{1'b0}})
                           - (rx_s ? CW'(1) : {CW{1'b0}});
            done_r <= (cmd_fire_s && (cmd_len == {LEN_W{1'b0}})) || last_pop_s;
        end
    end

    // FIFO storage write port (data only, pointers are reset elsewhere)
    always_ff @(posedge clk) begin
        if (mem_push_s) begin
            mem_r[wr_ptr_r] <= avm_readdata;
        end
    end

    // FIFO pointers/count and the registered output stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            mem_cnt_r   <= {CW{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_W{1'b0}};
            out_last_r  <= 1'b0;
            out_cnt_r   <= {LEN_W{1'b0}};
        end else begin
            if (mem_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (from_mem_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            mem_cnt_r <= mem_cnt_r + CW'(mem_push_s) - CW'(from_mem_s);
            // Load the output register when it is empty or being consumed.
            // Oldest beats come from the FIFO. A beat arriving into an empty
            // FIFO goes straight to the output register.
            if (load_s) begin
                if (from_mem_s || bypass_s) begin
                    out_valid_r <= 1'b1;
                    out_data_r  <= from_mem_s ? mem_r[rd_ptr_r] : avm_readdata;
                    out_last_r  <= ((out_cnt_r + LEN_W'(1)) == len_r);
                end else begin
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                end
            end
            if (cmd_fire_s) begin
                out_cnt_r <= {LEN_W{1'b0}};
            end else if (from_mem_s || bypass_s) begin
                out_cnt_r <= out_cnt_r + LEN_W'(1);
            end
        end
    end

    assign cmd_ready      = (state_r == ST_IDLE);
    assign busy           = (state_r != ST_IDLE);
    assign avm_read       = avm_read_s;
    assign avm_address    = addr_r;
    assign avm_burstcount = burst_s;
    assign out_valid      = out_valid_r;
    assign out_data       = out_data_r;
    assign out_last       = out_last_r;
    assign done           = done_r;

endmodule

// File: tb/tb_avmm_burst_reader.sv
// Testbench for avmm_burst_reader. It contains an Avalon slave model with a
// procedural memory and random stall/latency. Expected bursts and beats are
// queued when a command is accepted. A negedge monitor compares them against
// DUT activity.
module tb_avmm_burst_reader;

    localparam int DATA_W = 128;
    localparam int ADDR_W = 32;
    localparam int LEN_W  = 16;
    localparam int DEPTH  = 32;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [LEN_W-1:0]    cmd_len;
    logic [ADDR_W-1:0]   avm_address;
    logic [3:0]          avm_burstcount;
    logic                avm_read;
    logic                avm_waitrequest;
    logic [DATA_W-1:0]   avm_readdata;
    logic                avm_readdatavalid;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_data;
    logic                out_last;
    logic                busy;
    logic                done;

    avmm_burst_reader dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .avm_address(avm_address), .avm_burstcount(avm_burstcount), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [DATA_W-1:0] data; logic last; } beat_t;
    typedef struct packed { logic [ADDR_W-1:0] addr; logic [3:0] bc; } burst_t;

    beat_t              exp_beats[$];
    burst_t             exp_bursts[$];
    logic [ADDR_W-1:0]  pend[$];

    int errors = 0;
    int checks = 0;

    // Control knobs for the slave/consumer models
    bit hold_ready = 1'b0;
    bit rand_wait  = 1'b0;
    int force_wait = 0;

    // Monitor state
    bit                 done_pend = 1'b0;
    bit                 ahold_prev = 1'b0;
    logic [ADDR_W-1:0]  prev_addr;
    logic [3:0]         prev_bc;
    bit                 ohold_prev = 1'b0;
    logic [DATA_W-1:0]  prev_data;
    logic               prev_last;
    int                 inflight = 0;

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {a, a ^ 32'hA5A5_5A5A, ~a, a + 32'h1357_9BDF};
    endfunction

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Slave and consumer drivers, updated just after each rising edge
    always @(posedge clk) begin
        #1;
        out_ready = hold_ready ? 1'b0 : (($urandom % 10) < 7);
        if (force_wait > 0 && avm_read) begin
            avm_waitrequest = 1'b1;
            force_wait--;
        end else begin
            avm_waitrequest = rand_wait && (($urandom % 3) == 0);
        end
        if (pend.size() > 0 && ($urandom % 4) != 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = mem_word(pend.pop_front());
        end else begin
            avm_readdatavalid = 1'b0;
            avm_readdata      = {$urandom, $urandom, $urandom, $urandom};
        end
    end

    // Monitor: bursts, beats, done timing, hold-stability and buffer bound
    always @(negedge clk) begin
        if (!rst_n) begin
            pend.delete();
            done_pend  = 1'b0;
            ahold_prev = 1'b0;
            ohold_prev = 1'b0;
            inflight   = 0;
        end else begin
            if (done || done_pend) check("done_pulse", done, done_pend);
            done_pend = (out_valid && out_ready && out_last) ||
                        (cmd_valid && cmd_ready && cmd_len == 16'd0);

            if (ahold_prev) begin
                check("hold_read", avm_read, 1'b1);
                check("hold_addr", avm_address, prev_addr);
                check("hold_bc", avm_burstcount, prev_bc);
            end
            ahold_prev = avm_read && avm_waitrequest;
            prev_addr  = avm_address;
            prev_bc    = avm_burstcount;

            if (ohold_prev) begin
                check("out_hold_valid", out_valid, 1'b1);
                check("out_hold_data", out_data, prev_data);
                check("out_hold_last", out_last, prev_last);
            end
            ohold_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;

            if (out_valid && out_ready) begin
                inflight--;
                if (exp_beats.size() == 0) begin
                    fail_now("unexpected_beat");
                end else begin
                    beat_t b;
                    b = exp_beats.pop_front();
                    check("beat_data", out_data, b.data);
                    check("beat_last", out_last, b.last);
                end
            end

            if (avm_read && !avm_waitrequest) begin
                for (int i = 0; i < int'(avm_burstcount); i++)
                    pend.push_back(avm_address + ADDR_W'(i * 16));
                inflight += int'(avm_burstcount);
                if (exp_bursts.size() == 0) begin
                    fail_now("unexpected_burst");
                end else begin
                    burst_t eb;
                    eb = exp_bursts.pop_front();
                    check("burst_addr", avm_address, eb.addr);
                    check("burst_count", avm_burstcount, eb.bc);
                end
                check("buffer_bound", inflight <= DEPTH, 1'b1);
            end
        end
    end

    // Present a command, and on acceptance queue the bursts and beats expected from the spec rules
    task automatic start_cmd(input logic [ADDR_W-1:0] addr, input int len);
        int t;
        logic [ADDR_W-1:0] a;
        int rem;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_len   = LEN_W'(len);
        t = 0;
        while (1) begin
            @(negedge clk);
            if (cmd_ready) break;
            t++;
            if (t > 500) begin
                fail_now("cmd_accept_timeout");
                break;
            end
        end
        for (int i = 0; i < len; i++) begin
            beat_t b;
            b.data = mem_word(addr + ADDR_W'(i * 16));
            b.last = (i == len - 1);
            exp_beats.push_back(b);
        end
        a = addr;
        rem = len;
        while (rem > 0) begin
            burst_t eb;
            eb.addr = a;
            eb.bc   = 4'((rem > 8) ? 8 : rem);
            exp_bursts.push_back(eb);
            a   = a + ADDR_W'(int'(eb.bc) * 16);
            rem = rem - int'(eb.bc);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Wait, with a bounded cycle count, for done; then check the idle state and that nothing is left
    task automatic wait_done(input string name);
        int t;
        bit seen;
        t = 0;
        seen = 1'b0;
        while (t < 4000) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            t++;
        end
        if (!seen) begin
            $display("FAIL %s: done not seen within 4000 cycles", name);
            errors++;
            checks++;
        end else begin
            check({name, "_cmd_ready"}, cmd_ready, 1'b1);
            check({name, "_busy"}, busy, 1'b0);
            check({name, "_beats_left"}, exp_beats.size(), 0);
            check({name, "_bursts_left"}, exp_bursts.size(), 0);
        end
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_avm_read"}, avm_read, 1'b0);
        check({name, "_out_valid"}, out_valid, 1'b0);
        check({name, "_busy"}, busy, 1'b0);
        check({name, "_done"}, done, 1'b0);
        check({name, "_cmd_ready"}, cmd_ready, 1'b1);
    endtask

    // Main stimulus sequence
    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr = '0;
        cmd_len = '0;
        out_ready = 1'b0;
        avm_waitrequest = 1'b0;
        avm_readdata = '0;
        avm_readdatavalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // single full burst
        start_cmd(32'h2000_0000, 8);
        wait_done("len8");

        // 8/8/4 split
        start_cmd(32'h2000_0000, 20);
        wait_done("len20");

        // first request stalled for 5 cycles
        force_wait = 5;
        start_cmd(32'h2000_0400, 12);
        wait_done("stall");

        // consumer blocked, so the credit limit must hold
        hold_ready = 1'b1;
        start_cmd(32'h2000_0000, 64);
        repeat (100) @(posedge clk);
        #1;
        hold_ready = 1'b0;
        wait_done("backpressure");

        // zero-length no-op
        start_cmd(32'h2000_0000, 0);
        wait_done("len0");

        // random stalls, random commands, address wrap
        rand_wait = 1'b1;
        start_cmd(32'hFFFF_FFC0, 10);
        wait_done("wrap");
        for (int k = 0; k < 8; k++) begin
            start_cmd($urandom & 32'hFFFF_FFF0, $urandom_range(1, 40));
            wait_done("random");
        end

        // reset in the middle of a command, then a clean command
        start_cmd(32'h2000_1000, 32);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_beats.delete();
        exp_bursts.delete();
        @(negedge clk);
        check_reset_state("midreset");
        start_cmd(32'h2000_0000, 8);
        wait_done("after_reset");

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
